// File: rtl/dense_2_packer.sv
// Frame packer for the 128-bit bit-serial dense stage. It collects narrow beats MSB-first into
// frames and issues each frame as a single-cycle pulse, spaced at least ISSUE_GAP cycles apart.
module dense_2_packer #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned FRAME_BITS = 128,
  parameter int unsigned ISSUE_GAP  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_in,
  input  logic [IN_WIDTH-1:0]   data_in,
  output logic                  rdy_in,
  output logic                  vld_out,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  drop_err
);

  localparam int unsigned BEATS = FRAME_BITS / IN_WIDTH;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GW    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);
  localparam logic [GW-1:0] GapLoad  = GW'(ISSUE_GAP - 1);

  logic [CW-1:0]         beat_cnt_q;
  logic [FRAME_BITS-1:0] hold_q;
  logic                  hold_vld_q;
  logic [GW-1:0]         gap_cnt_q;

  logic [FRAME_BITS-1:0] frame_next;
  logic                  last_beat;
  logic                  issue_now;
  logic                  accept;
  logic                  load;

  always_comb begin
    last_beat = (beat_cnt_q == LastBeat);
    issue_now = hold_vld_q && (gap_cnt_q == '0);
    // Only a final beat can stall: it would overwrite a frame still waiting to issue.
    rdy_in    = !(last_beat && hold_vld_q && !issue_now);
    accept    = vld_in && rdy_in;
    load      = accept && last_beat;
  end

  // Single-beat frames need no shift register; the beat is the whole frame.
  if (BEATS > 1) begin : g_pack
    logic [FRAME_BITS-IN_WIDTH-1:0] pack_q;

    assign frame_next = {pack_q, data_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pack_q <= '0;
      end else if (accept) begin
        pack_q <= frame_next[FRAME_BITS-IN_WIDTH-1:0];
      end
    end
  end else begin : g_nopack
    assign frame_next = data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      gap_cnt_q  <= '0;
      vld_out    <= 1'b0;
      data_out   <= '0;
      drop_err   <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CW'(1);
      end

      if (vld_in && !rdy_in) begin
        drop_err <= 1'b1;
      end

      if (load) begin
        hold_q <= frame_next;
      end

      // A load on the issuing edge keeps the hold stage occupied with the new frame.
      if (load) begin
        hold_vld_q <= 1'b1;
      end else if (issue_now) begin
        hold_vld_q <= 1'b0;
      end

      if (issue_now) begin
        data_out  <= hold_q;
        vld_out   <= 1'b1;
        gap_cnt_q <= GapLoad;
      end else begin
        vld_out <= 1'b0;
        if (gap_cnt_q != '0) begin
          gap_cnt_q <= gap_cnt_q - GW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_2_packer.sv
// Bench for dense_2_packer: a default-parameter instance checked against a queue/timestamp model,
// plus a single-beat, gap-1 instance checked against a two-stage delay line.
module tb_dense_2_packer;

  localparam int unsigned IW    = 8;
  localparam int unsigned FB    = 128;
  localparam int unsigned GAP   = 128;
  localparam int unsigned BEATS = FB / IW;
  localparam logic [127:0] Pattern = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld_in = 1'b0;
  logic [7:0]    data_in = '0;
  logic          rdy_in;
  logic          vld_out;
  logic [127:0]  data_out;
  logic          drop_err;

  logic          vld_in_w = 1'b0;
  logic [127:0]  data_in_w = '0;
  logic          rdy_in_w;
  logic          vld_out_w;
  logic [127:0]  data_out_w;
  logic          drop_err_w;

  dense_2_packer #(.IN_WIDTH(IW), .FRAME_BITS(FB), .ISSUE_GAP(GAP)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .rdy_in   (rdy_in),
    .vld_out  (vld_out),
    .data_out (data_out),
    .drop_err (drop_err)
  );

  dense_2_packer #(.IN_WIDTH(128), .FRAME_BITS(128), .ISSUE_GAP(1)) u_dut_w (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in_w),
    .data_in  (data_in_w),
    .rdy_in   (rdy_in_w),
    .vld_out  (vld_out_w),
    .data_out (data_out_w),
    .drop_err (drop_err_w)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: partial frame as a beat queue, one waiting frame, last issue time in edges.
  logic [7:0]   cur[$];
  logic [127:0] m_hold = '0;
  bit           m_hold_vld = 1'b0;
  int           last_issue = -1000;
  int           edge_n = 0;
  bit           m_drop = 1'b0;
  logic [127:0] m_data = '0;
  bit           m_vld = 1'b0;
  int           issue_edges[$];

  bit           w_hv = 1'b0;
  logic [127:0] w_hd = '0;
  bit           w_vld = 1'b0;
  logic [127:0] w_data = '0;

  function automatic bit m_issue();
    return m_hold_vld && (edge_n - last_issue >= int'(GAP));
  endfunction

  function automatic bit m_rdy();
    return !(cur.size() == BEATS - 1 && m_hold_vld && !m_issue());
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit wv,
                            input logic [127:0] wd);
    bit           iss;
    bit           rdy;
    bit           full;
    logic [127:0] fr;
    iss  = m_issue();
    rdy  = m_rdy();
    full = 1'b0;
    fr   = '0;
    if (v && !rdy) m_drop = 1'b1;
    if (v && rdy) begin
      cur.push_back(d);
      if (cur.size() == BEATS) begin
        foreach (cur[i]) fr |= 128'(cur[i]) << (FB - (i + 1) * IW);
        cur.delete();
        full = 1'b1;
      end
    end
    if (iss) begin
      m_data     = m_hold;
      m_vld      = 1'b1;
      last_issue = edge_n;
      m_hold_vld = 1'b0;
    end else begin
      m_vld = 1'b0;
    end
    if (full) begin
      m_hold     = fr;
      m_hold_vld = 1'b1;
    end
    w_vld = w_hv;
    if (w_hv) w_data = w_hd;
    w_hv = wv;
    if (wv) w_hd = wd;
    edge_n++;
  endtask

  // One clock: drive at the falling edge, check ready, clock, then check outputs at the next fall.
  task automatic cycle(input bit v, input logic [7:0] d);
    bit           wv;
    logic [127:0] wd;
    wv = ($urandom_range(7) != 0);
    wd = {$urandom(), $urandom(), $urandom(), $urandom()};
    vld_in    = v;
    data_in   = d;
    vld_in_w  = wv;
    data_in_w = wd;
    #1;
    chk("rdy_in", rdy_in, m_rdy());
    chk("rdy_in_w", rdy_in_w, 1);
    @(posedge clk);
    model_edge(v, d, wv, wd);
    @(negedge clk);
    chk("vld_out", vld_out, m_vld);
    chk("data_out", data_out, m_data);
    chk("drop_err", drop_err, m_drop);
    chk("vld_out_w", vld_out_w, w_vld);
    chk("data_out_w", data_out_w, w_data);
    chk("drop_err_w", drop_err_w, 0);
    if (vld_out === 1'b1) issue_edges.push_back(edge_n);
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, 8'($urandom()));
  endtask

  task automatic send(input logic [7:0] d, input bit honor);
    int guard;
    guard = 0;
    while (honor && !m_rdy()) begin
      cycle(1'b0, 8'h00);
      guard++;
      if (guard > 1000) begin
        fail_now("send_wait");
        break;
      end
    end
    cycle(1'b1, d);
  endtask

  task automatic send_pattern();
    for (int i = 0; i < 16; i++) send({4'(15 - i), 4'(i)}, 1'b1);
  endtask

  task automatic send_random(input int k, input bit honor);
    for (int i = 0; i < k; i++) send(8'($urandom()), honor);
  endtask

  // Asynchronous reset with garbage on vld_in; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst      = 1'b1;
    vld_in   = 1'b1;
    data_in  = 8'hA5;
    vld_in_w = 1'b1;
    #1;
    chk("rst_vld_out", vld_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_rdy_in", rdy_in, 1);
    chk("rst_vld_out_w", vld_out_w, 0);
    chk("rst_data_out_w", data_out_w, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    vld_in = 1'b0;
    cur.delete();
    m_hold     = '0;
    m_hold_vld = 1'b0;
    last_issue = edge_n - 1000;
    m_drop     = 1'b0;
    m_data     = '0;
    m_vld      = 1'b0;
    w_hv       = 1'b0;
    w_hd       = '0;
    w_vld      = 1'b0;
    w_data     = '0;
    issue_edges.delete();
  endtask

  initial begin
    int guard;
    @(negedge clk);
    do_reset();

    // Known pattern, then the 2-edge issue latency.
    send_pattern();
    cycle(1'b0, 8'h00);
    chk("latency_vld", vld_out, 1);
    chk("pattern", data_out, Pattern);
    idle(3);

    // Three frames back to back: two stream freely, the third stalls on its final beat.
    do_reset();
    send_random(48, 1'b1);
    idle(300);
    chk("issue_count", issue_edges.size(), 3);
    if (issue_edges.size() == 3) begin
      chk("spacing_01", issue_edges[1] - issue_edges[0], GAP);
      chk("spacing_12", issue_edges[2] - issue_edges[1], GAP);
    end

    // Source ignores ready: beats get dropped and the error sticks.
    do_reset();
    send_random(64, 1'b0);
    idle(300);
    chk("drop_sticky", drop_err, 1);

    // Reset after a partial frame, then again while the issued frame is on the output.
    do_reset();
    send_random(9, 1'b1);
    do_reset();
    send_random(16, 1'b1);
    cycle(1'b0, 8'h00);
    chk("pre_rst_vld", vld_out, 1);
    do_reset();
    send_pattern();
    cycle(1'b0, 8'h00);
    chk("post_rst_vld", vld_out, 1);
    chk("post_rst_data", data_out, Pattern);
    idle(3);

    // Final beat of a frame landing on the very edge the waiting frame issues.
    do_reset();
    send_random(32, 1'b1);
    send_random(15, 1'b1);
    guard = 0;
    while (!m_issue() && guard < 300) begin
      cycle(1'b0, 8'h00);
      guard++;
    end
    if (guard >= 300) fail_now("coincide_wait");
    issue_edges.delete();
    send(8'($urandom()), 1'b0);
    chk("coincide_vld", vld_out, 1);
    idle(GAP + 5);
    chk("coincide_count", issue_edges.size(), 2);
    if (issue_edges.size() == 2) chk("coincide_gap", issue_edges[1] - issue_edges[0], GAP);
    chk("coincide_nodrop", drop_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
